// File: rtl/rc4_task_sequencer.sv
// rtl/rc4_task_sequencer.sv - RC4 task sequencer and S-memory arbiter
// Purpose:
//   Runs the three S-memory tasks in fixed order (init, key-schedule shuffle,
//   PRGA) through start/fin handshakes. Only the active task reaches the
//   single-port S memory. A watchdog traps a task that never finishes.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     begin a full sequence (honoured in IDLE only)
//   init/shuf/prga_start      1-cycle start pulse to each task FSM
//   init/shuf/prga_fin        fin strobe from each task FSM
//   init/shuf/prga_addr/data/wren  per-task S-memory request
//   mem_addr/mem_data/mem_wren     muxed S-memory request
//   owner                     00 none, 01 init, 10 shuffle, 11 prga
//   busy                      high from INIT_GO through PRGA_WAIT
//   done                      1-cycle strobe on sequence completion
//   err, err_task             sticky timeout flag, owner code of stuck task
module rc4_task_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              init_start,
  input  logic              init_fin,
  output logic              shuf_start,
  input  logic              shuf_fin,
  output logic              prga_start,
  input  logic              prga_fin,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [ADDR_W-1:0] shuf_addr,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic [DATA_W-1:0] shuf_data,
  input  logic [DATA_W-1:0] prga_data,
  input  logic              init_wren,
  input  logic              shuf_wren,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic [1:0]        owner,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_task
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT_GO, S_INIT_WAIT, S_SHUF_GO, S_SHUF_WAIT,
    S_PRGA_GO, S_PRGA_WAIT, S_DONE, S_ERR
  } state_t;

  localparam logic [1:0]  OWN_NONE  = 2'b00;
  localparam logic [1:0]  OWN_INIT  = 2'b01;
  localparam logic [1:0]  OWN_SHUF  = 2'b10;
  localparam logic [1:0]  OWN_PRGA  = 2'b11;
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] wdog_q;
  logic [1:0]  owner_q;
  logic        init_start_q, shuf_start_q, prga_start_q;
  logic        busy_q, done_q, err_q;
  logic [1:0]  err_task_q;
  logic        waiting;
  logic        timed_out;

  assign waiting   = (state_q == S_INIT_WAIT) || (state_q == S_SHUF_WAIT) ||
                     (state_q == S_PRGA_WAIT);
  assign timed_out = (wdog_q == WDOG_LAST);

  // Next state. In a WAIT state the fin check comes first so a fin arriving
  // on the timeout cycle still completes the task.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_INIT_GO;
      S_INIT_GO:   state_d = S_INIT_WAIT;
      S_INIT_WAIT: if (init_fin) state_d = S_SHUF_GO;
                   else if (timed_out) state_d = S_ERR;
      S_SHUF_GO:   state_d = S_SHUF_WAIT;
      S_SHUF_WAIT: if (shuf_fin) state_d = S_PRGA_GO;
                   else if (timed_out) state_d = S_ERR;
      S_PRGA_GO:   state_d = S_PRGA_WAIT;
      S_PRGA_WAIT: if (prga_fin) state_d = S_DONE;
                   else if (timed_out) state_d = S_ERR;
      S_DONE:      state_d = S_IDLE;
      S_ERR:       state_d = S_ERR;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state, so each one is valid
  // in exactly the cycle the FSM occupies the matching state. owner switching
  // on GO entry lets the task's first address reach memory immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wdog_q       <= '0;
      owner_q      <= OWN_NONE;
      init_start_q <= 1'b0;
      shuf_start_q <= 1'b0;
      prga_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_task_q   <= OWN_NONE;
    end else begin
      state_q <= state_d;
      // Cleared outside WAIT, so every WAIT starts counting from zero.
      if (waiting) begin
        if (wdog_q != 16'hFFFF) wdog_q <= wdog_q + 16'd1;
      end else begin
        wdog_q <= '0;
      end
      init_start_q <= (state_d == S_INIT_GO);
      shuf_start_q <= (state_d == S_SHUF_GO);
      prga_start_q <= (state_d == S_PRGA_GO);
      busy_q       <= (state_d != S_IDLE) && (state_d != S_DONE) &&
                      (state_d != S_ERR);
      done_q       <= (state_d == S_DONE);
      err_q        <= (state_d == S_ERR);
      if ((state_d == S_ERR) && (state_q != S_ERR)) err_task_q <= owner_q;
      case (state_d)
        S_INIT_GO, S_INIT_WAIT: owner_q <= OWN_INIT;
        S_SHUF_GO, S_SHUF_WAIT: owner_q <= OWN_SHUF;
        S_PRGA_GO, S_PRGA_WAIT: owner_q <= OWN_PRGA;
        default:                owner_q <= OWN_NONE;
      endcase
    end
  end

  // Memory mux: non-owning tasks are fully masked.
  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    case (owner_q)
      OWN_INIT: begin
        mem_addr = init_addr;
        mem_data = init_data;
        mem_wren = init_wren;
      end
      OWN_SHUF: begin
        mem_addr = shuf_addr;
        mem_data = shuf_data;
        mem_wren = shuf_wren;
      end
      OWN_PRGA: begin
        mem_addr = prga_addr;
        mem_data = prga_data;
        mem_wren = prga_wren;
      end
      default: ;
    endcase
  end

  assign init_start = init_start_q;
  assign shuf_start = shuf_start_q;
  assign prga_start = prga_start_q;
  assign owner      = owner_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_task   = err_task_q;

endmodule

// File: tb/tb_rc4_task_sequencer.sv
// tb/tb_rc4_task_sequencer.sv - self-checking bench for rc4_task_sequencer
module tb_rc4_task_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       init_start, shuf_start, prga_start;
  logic       init_fin_a = 1'b0, shuf_fin_a = 1'b0, prga_fin_a = 1'b0;
  logic       shuf_fin_x = 1'b0, prga_fin_x = 1'b0;
  logic [7:0] init_addr = '0, shuf_addr = '0, prga_addr = '0;
  logic [7:0] init_data = '0, shuf_data = '0, prga_data = '0;
  logic       init_wren = 1'b0, shuf_wren = 1'b0, prga_wren = 1'b0;
  logic [7:0] mem_addr, mem_data;
  logic       mem_wren;
  logic [1:0] owner, err_task;
  logic       busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int dly_i = 0, dly_s = 0, dly_p = 0;
  int ci = 0, cs = 0, cp = 0;
  logic err_seen = 1'b0;
  int exp_q[$];
  int obs_q[$];
  int exp_ev, obs_ev;

  rc4_task_sequencer #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .init_start(init_start), .init_fin(init_fin_a),
    .shuf_start(shuf_start), .shuf_fin(shuf_fin_a | shuf_fin_x),
    .prga_start(prga_start), .prga_fin(prga_fin_a | prga_fin_x),
    .init_addr(init_addr), .shuf_addr(shuf_addr), .prga_addr(prga_addr),
    .init_data(init_data), .shuf_data(shuf_data), .prga_data(prga_data),
    .init_wren(init_wren), .shuf_wren(shuf_wren), .prga_wren(prga_wren),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .owner(owner), .busy(busy), .done(done), .err(err), .err_task(err_task)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Task FSM stand-ins: each fins dly cycles after seeing its start (0 = never).
  initial begin
    forever begin
      @(negedge clk);
      init_fin_a = 1'b0; shuf_fin_a = 1'b0; prga_fin_a = 1'b0;
      if (!busy) begin ci = 0; cs = 0; cp = 0; end
      if (ci > 0) begin ci--; if (ci == 0) init_fin_a = 1'b1; end
      if (cs > 0) begin cs--; if (cs == 0) shuf_fin_a = 1'b1; end
      if (cp > 0) begin cp--; if (cp == 0) prga_fin_a = 1'b1; end
      if (init_start) ci = dly_i;
      if (shuf_start) cs = dly_s;
      if (prga_start) cp = dly_p;
    end
  end

  // Event code: kind 1 init_start, 2 shuf_start, 3 prga_start, 4 done, 5 err.
  function automatic int ev(input int kind, input int c);
    return kind * 100000 + c;
  endfunction

  task automatic step();
    @(negedge clk);
    if (init_start) obs_q.push_back(ev(1, cyc));
    if (shuf_start) obs_q.push_back(ev(2, cyc));
    if (prga_start) obs_q.push_back(ev(3, cyc));
    if (done) obs_q.push_back(ev(4, cyc));
    if (err && !err_seen) obs_q.push_back(ev(5, cyc));
    err_seen = err;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Start driven in cycle s is sampled at the next edge, so INIT_GO is s+1.
  task automatic push_seq(input int s, input int a, input int b, input int c);
    exp_q.push_back(ev(1, s + 1));
    exp_q.push_back(ev(2, s + 2 + a));
    exp_q.push_back(ev(3, s + 3 + a + b));
    exp_q.push_back(ev(4, s + 4 + a + b + c));
  endtask

  task automatic begin_seq(input int a, input int b, input int c, output int s);
    dly_i = a; dly_s = b; dly_p = c;
    s = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    init_addr = 8'h11; init_data = 8'h22; init_wren = 1'b1;
    prga_addr = 8'h33; prga_wren = 1'b1;
    do_reset();
    n_cmp++; if (owner !== 2'b00) begin n_bad++; $display("FAIL reset_owner: got %0h want 0", owner); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b want 0", err); end
    n_cmp++; if (err_task !== 2'b00) begin n_bad++; $display("FAIL reset_err_task: got %0h want 0", err_task); end
    n_cmp++; if (init_start !== 1'b0) begin n_bad++; $display("FAIL reset_init_start: got %0b want 0", init_start); end
    n_cmp++; if (mem_wren !== 1'b0) begin n_bad++; $display("FAIL reset_mem_wren: got %0b want 0", mem_wren); end
    n_cmp++; if (mem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
    step();
    n_cmp++; if (owner !== 2'b00) begin n_bad++; $display("FAIL idle_owner: got %0h want 0", owner); end
    init_wren = 1'b0; prga_wren = 1'b0;
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL reset_events: got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_basic();
    int s;
    do_reset();
    begin_seq(10, 10, 10, s);
    push_seq(s, 10, 10, 10);
    for (int i = 0; i < 35; i++) begin
      step();
      if (cyc == s + 20) begin
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %0b want 1", busy); end
      end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_end: got %0b want 0", busy); end
    while (exp_q.size() > 0) begin
      exp_ev = exp_q.pop_front();
      if (obs_q.size() > 0) obs_ev = obs_q.pop_front(); else obs_ev = -1;
      n_cmp++; if (obs_ev !== exp_ev) begin n_bad++; $display("FAIL basic_event: got %0d want %0d", obs_ev, exp_ev); end
    end
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL basic_extra: got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_mux();
    int s;
    do_reset();
    init_addr = 8'h11; init_data = 8'h22; init_wren = 1'b1;
    shuf_addr = 8'h5C; shuf_data = 8'h33; shuf_wren = 1'b0;
    prga_addr = 8'hAA; prga_data = 8'hBB; prga_wren = 1'b1;
    begin_seq(3, 12, 3, s);
    push_seq(s, 3, 12, 3);
    n_cmp++; if (mem_addr !== 8'h11) begin n_bad++; $display("FAIL mux_go_addr: got %0h want 11", mem_addr); end
    n_cmp++; if (mem_wren !== 1'b1) begin n_bad++; $display("FAIL mux_go_wren: got %0b want 1", mem_wren); end
    while (cyc < s + 7) step();
    n_cmp++; if (mem_wren !== 1'b0) begin n_bad++; $display("FAIL mux_shuf_wren: got %0b want 0", mem_wren); end
    n_cmp++; if (mem_addr !== 8'h5C) begin n_bad++; $display("FAIL mux_shuf_addr: got %0h want 5c", mem_addr); end
    n_cmp++; if (mem_data !== 8'h33) begin n_bad++; $display("FAIL mux_shuf_data: got %0h want 33", mem_data); end
    shuf_wren = 1'b1; #1;
    n_cmp++; if (mem_wren !== 1'b1) begin n_bad++; $display("FAIL mux_shuf_wren_on: got %0b want 1", mem_wren); end
    init_wren = 1'b0; shuf_wren = 1'b0; prga_wren = 1'b0;
    while (cyc < s + 24) step();
    while (exp_q.size() > 0) begin
      exp_ev = exp_q.pop_front();
      if (obs_q.size() > 0) obs_ev = obs_q.pop_front(); else obs_ev = -1;
      n_cmp++; if (obs_ev !== exp_ev) begin n_bad++; $display("FAIL mux_event: got %0d want %0d", obs_ev, exp_ev); end
    end
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL mux_extra: got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_stray_fin();
    int s;
    do_reset();
    begin_seq(10, 4, 4, s);
    push_seq(s, 10, 4, 4);
    while (cyc < s + 4) step();
    shuf_fin_x = 1'b1; prga_fin_x = 1'b1;
    step();
    shuf_fin_x = 1'b0; prga_fin_x = 1'b0;
    n_cmp++; if (owner !== 2'b01) begin n_bad++; $display("FAIL stray_owner: got %0h want 1", owner); end
    n_cmp++; if (shuf_start !== 1'b0) begin n_bad++; $display("FAIL stray_shuf_start: got %0b want 0", shuf_start); end
    while (cyc < s + 24) step();
    while (exp_q.size() > 0) begin
      exp_ev = exp_q.pop_front();
      if (obs_q.size() > 0) obs_ev = obs_q.pop_front(); else obs_ev = -1;
      n_cmp++; if (obs_ev !== exp_ev) begin n_bad++; $display("FAIL stray_event: got %0d want %0d", obs_ev, exp_ev); end
    end
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL stray_extra: got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_timeout_err();
    int s;
    do_reset();
    begin_seq(3, 0, 3, s);
    // SHUF_GO at s+5; 16 WAIT cycles (wdog 0..15) then ERR.
    exp_q.push_back(ev(1, s + 1));
    exp_q.push_back(ev(2, s + 5));
    exp_q.push_back(ev(5, s + 22));
    while (cyc < s + 23) step();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL to_err: got %0b want 1", err); end
    n_cmp++; if (err_task !== 2'b10) begin n_bad++; $display("FAIL to_err_task: got %0h want 2", err_task); end
    n_cmp++; if (owner !== 2'b00) begin n_bad++; $display("FAIL to_owner: got %0h want 0", owner); end
    start = 1'b1;
    for (int i = 0; i < 4; i++) step();
    start = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL to_busy_after_start: got %0b want 0", busy); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL to_err_sticky: got %0b want 1", err); end
    n_cmp++; if (err_task !== 2'b10) begin n_bad++; $display("FAIL to_err_task_held: got %0h want 2", err_task); end
    while (exp_q.size() > 0) begin
      exp_ev = exp_q.pop_front();
      if (obs_q.size() > 0) obs_ev = obs_q.pop_front(); else obs_ev = -1;
      n_cmp++; if (obs_ev !== exp_ev) begin n_bad++; $display("FAIL to_event: got %0d want %0d", obs_ev, exp_ev); end
    end
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL to_extra: got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_fin_wins();
    int s;
    do_reset();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL fw_err_cleared: got %0b want 0", err); end
    // PRGA_GO at s+7; fin lands at s+23 where wdog==15.
    begin_seq(2, 2, 16, s);
    push_seq(s, 2, 2, 16);
    while (cyc < s + 26) step();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL fw_err: got %0b want 0", err); end
    while (exp_q.size() > 0) begin
      exp_ev = exp_q.pop_front();
      if (obs_q.size() > 0) obs_ev = obs_q.pop_front(); else obs_ev = -1;
      n_cmp++; if (obs_ev !== exp_ev) begin n_bad++; $display("FAIL fw_event: got %0d want %0d", obs_ev, exp_ev); end
    end
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL fw_extra: got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_abort();
    int s;
    do_reset();
    begin_seq(2, 2, 0, s);
    exp_q.push_back(ev(1, s + 1));
    exp_q.push_back(ev(2, s + 4));
    exp_q.push_back(ev(3, s + 7));
    while (cyc < s + 10) step();
    prga_addr = 8'h77; prga_wren = 1'b1; #1;
    n_cmp++; if (mem_wren !== 1'b1) begin n_bad++; $display("FAIL ra_pre_wren: got %0b want 1", mem_wren); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ra_busy: got %0b want 0", busy); end
    n_cmp++; if (mem_wren !== 1'b0) begin n_bad++; $display("FAIL ra_mem_wren: got %0b want 0", mem_wren); end
    n_cmp++; if (owner !== 2'b00) begin n_bad++; $display("FAIL ra_owner: got %0h want 0", owner); end
    prga_wren = 1'b0;
    begin_seq(10, 10, 10, s);
    push_seq(s, 10, 10, 10);
    while (cyc < s + 36) step();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ra_err: got %0b want 0", err); end
    while (exp_q.size() > 0) begin
      exp_ev = exp_q.pop_front();
      if (obs_q.size() > 0) obs_ev = obs_q.pop_front(); else obs_ev = -1;
      n_cmp++; if (obs_ev !== exp_ev) begin n_bad++; $display("FAIL ra_event: got %0d want %0d", obs_ev, exp_ev); end
    end
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL ra_extra: got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mux();
    test_stray_fin();
    test_timeout_err();
    test_fin_wins();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
